// File: rtl/pipe_tree_mux_pkg.sv
// Shared constants and configuration checks for the pipelined tree multiplexers.
package pipe_tree_mux_pkg;

  localparam int MIN_LEVEL = 2;

  // Number of leaf inputs for a tree of the given depth.
  function automatic int tree_inputs(input int level);
    return 1 << (level - 1);
  endfunction

  // Select bits still pending at the input of a stage. The last stage
  // forwards a single dummy bit so that no vector collapses to zero width.
  function automatic int stage_sel_w(input int level, input int stage);
    int w;
    w = level - 1 - stage;
    return (w < 1) ? 1 : w;
  endfunction

  // The binary select must hold exactly one bit per tree stage.
  function automatic bit sel_width_ok(input int level, input int sel_sz);
    return (level >= MIN_LEVEL) && (sel_sz == level - 1);
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One tree layer: halves the candidate slots using the lowest pending select
// bit, then registers data, remaining select bits, tag and valid. The whole
// slice freezes while the downstream consumer is stalling.
module mux_tree_stage
  import pipe_tree_mux_pkg::*;
#(
  parameter int LEVEL   = 4,
  parameter int STAGE   = 0,
  parameter int DATA_SZ = 4,
  parameter int TAG_SZ  = 2,
  localparam int CI     = tree_inputs(LEVEL) >> STAGE,
  localparam int CO     = CI / 2,
  localparam int SI     = stage_sel_w(LEVEL, STAGE),
  localparam int SO     = stage_sel_w(LEVEL, STAGE + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  valid_i,
  input  logic [CI*DATA_SZ-1:0] data_i,
  input  logic [SI-1:0]         sel_i,
  input  logic [TAG_SZ-1:0]     tag_i,
  output logic                  valid_o,
  output logic [CO*DATA_SZ-1:0] data_o,
  output logic [SO-1:0]         sel_o,
  output logic [TAG_SZ-1:0]     tag_o
);

  logic [CO*DATA_SZ-1:0] data_d;
  logic [SO-1:0]         sel_d;
  logic                  valid_q;
  logic [CO*DATA_SZ-1:0] data_q;
  logic [SO-1:0]         sel_q;
  logic [TAG_SZ-1:0]     tag_q;

  // Pair 2j/2j+1 collapses to output slot j; bit 0 of the select picks odd.
  genvar gi;
  for (gi = 0; gi < CO; gi++) begin : g_pair
    assign data_d[gi*DATA_SZ +: DATA_SZ] = sel_i[0] ? data_i[(2*gi+1)*DATA_SZ +: DATA_SZ]
                                                    : data_i[(2*gi)*DATA_SZ +: DATA_SZ];
  end

  // The consumed bit drops off; later stages see only what is left.
  assign sel_d = SO'(sel_i >> 1);

  // Register slice: advance in lock-step with the tree, hold on stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      tag_q   <= '0;
    end else if (!stall_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      sel_q   <= sel_d;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipe_tree_mux.sv
// Pipelined N:1 multiplexer built as a registered binary reduction tree with
// valid/ready flow control. One request per cycle, LEVEL-1 cycles latency.
module pipe_tree_mux
  import pipe_tree_mux_pkg::*;
#(
  parameter int LEVEL   = 4,
  parameter int DATA_SZ = 4,
  parameter int SEL_SZ  = LEVEL - 1,
  parameter int TAG_SZ  = 2,
  localparam int N      = tree_inputs(LEVEL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DATA_SZ-1:0] raw,
  input  logic [SEL_SZ-1:0]    sel,
  input  logic [TAG_SZ-1:0]    in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SZ-1:0]   result,
  output logic [TAG_SZ-1:0]    out_tag
);

  localparam int STAGES = LEVEL - 1;

  if (!sel_width_ok(LEVEL, SEL_SZ)) begin : g_bad_cfg
    $error("pipe_tree_mux: SEL_SZ must equal LEVEL-1 and LEVEL must be >= 2");
  end

  // A held output beat freezes the whole tree and blocks new requests.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_st
    localparam int CI = N >> gi;
    localparam int CO = CI / 2;
    localparam int SI = stage_sel_w(LEVEL, gi);
    localparam int SO = stage_sel_w(LEVEL, gi + 1);

    logic                  v_in;
    logic [CI*DATA_SZ-1:0] d_in;
    logic [SI-1:0]         s_in;
    logic [TAG_SZ-1:0]     t_in;
    logic                  v_out;
    logic [CO*DATA_SZ-1:0] d_out;
    logic [SO-1:0]         s_out;
    logic [TAG_SZ-1:0]     t_out;

    if (gi == 0) begin : g_head
      assign v_in = in_valid;
      assign d_in = raw;
      assign s_in = sel;
      assign t_in = in_tag;
    end else begin : g_link
      assign v_in = g_st[gi-1].v_out;
      assign d_in = g_st[gi-1].d_out;
      assign s_in = g_st[gi-1].s_out;
      assign t_in = g_st[gi-1].t_out;
    end

    mux_tree_stage #(
      .LEVEL   (LEVEL),
      .STAGE   (gi),
      .DATA_SZ (DATA_SZ),
      .TAG_SZ  (TAG_SZ)
    ) u_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .stall_i (stall),
      .valid_i (v_in),
      .data_i  (d_in),
      .sel_i   (s_in),
      .tag_i   (t_in),
      .valid_o (v_out),
      .data_o  (d_out),
      .sel_o   (s_out),
      .tag_o   (t_out)
    );
  end

  assign out_valid = g_st[STAGES-1].v_out;
  assign result    = g_st[STAGES-1].d_out;
  assign out_tag   = g_st[STAGES-1].t_out;

  // The final stage's leftover select bit carries no information.
  logic unused_sel;
  assign unused_sel = ^g_st[STAGES-1].s_out;

endmodule
